// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: synchronous-read word array filled at run time
// through a beat-wise valid/ready loader. Unwritten words read back as NOP_WORD.
module instr_mem_loadable #(
  parameter int                 INS_ADDRESS = 9,
  parameter int                 INS_W       = 32,
  parameter int                 LOAD_W      = 8,
  parameter logic [INS_W-1:0]   NOP_WORD    = INS_W'(32'h00007033)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [INS_ADDRESS-1:0] ra,
  output logic [INS_W-1:0]       rd,
  output logic                   rd_misalign,
  output logic                   fetch_stall,
  input  logic                   ld_start,
  input  logic [INS_ADDRESS-1:0] ld_base,
  input  logic                   ld_valid,
  input  logic [LOAD_W-1:0]      ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_done,
  output logic                   ld_wrap
);

  localparam int AW    = INS_ADDRESS - 2;
  localparam int DEPTH = 1 << AW;
  localparam int BEATS = INS_W / LOAD_W;
  localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [AW-1:0]      r_ptr;
  logic [CW-1:0]      r_cnt;
  logic [INS_W-1:0]   r_asm;
  logic               r_wrap;
  logic [DEPTH-1:0]   r_valid;
  logic [INS_W-1:0]   r_mem [DEPTH];
  logic [INS_W-1:0]   r_rd_p1;
  logic               r_misalign_p1;

  logic               w_accept;
  logic               w_cnt_full;
  logic               w_commit;
  logic               w_full_commit;
  logic [INS_W-1:0]   w_word;
  logic [AW-1:0]      w_idx;
  logic               w_unused_base;

  // Position a loader beat at its bit offset inside the instruction word.
  function automatic logic [INS_W-1:0] place_beat(input logic [LOAD_W-1:0] d,
                                                  input logic [CW-1:0]     c);
    return INS_W'(d) << (LOAD_W * int'(c));
  endfunction

  assign w_idx         = ra[INS_ADDRESS-1:2];
  assign w_unused_base = ^ld_base[1:0];
  assign w_accept      = (r_state == S_LOAD) && ld_valid;
  assign w_cnt_full    = (r_cnt == CW'(BEATS - 1));
  assign w_word        = r_asm | place_beat(ld_data, r_cnt);
  // A word is written either when its top beat lands or when the loader ends early.
  assign w_commit      = w_accept && (w_cnt_full || ld_last);
  assign w_full_commit = w_accept && w_cnt_full;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; ld_start is only honoured from IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (ld_start) w_state_nxt = S_LOAD;
      S_LOAD:  if (w_accept && ld_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs decoded straight from the state.
  always_comb begin
    ld_ready    = (r_state == S_LOAD);
    ld_done     = (r_state == S_DONE);
    fetch_stall = (r_state != S_IDLE);
  end

  // Loader write pointer, beat counter, word assembly and sticky wrap flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr  <= '0;
      r_cnt  <= '0;
      r_asm  <= '0;
      r_wrap <= 1'b0;
    end else if ((r_state == S_IDLE) && ld_start) begin
      r_ptr  <= ld_base[INS_ADDRESS-1:2];
      r_cnt  <= '0;
      r_asm  <= '0;
      r_wrap <= 1'b0;
    end else if (w_accept) begin
      if (w_commit) begin
        r_asm <= '0;
        r_cnt <= '0;
        if (w_full_commit) begin
          r_ptr <= r_ptr + AW'(1);
          if (r_ptr == {AW{1'b1}}) r_wrap <= 1'b1;
        end
      end else begin
        r_asm <= w_word;
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Per-word valid bits; the only storage cleared by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_valid <= '0;
    else if (w_commit) r_valid[r_ptr] <= 1'b1;
  end

  // Word array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[r_ptr] <= w_word;
  end

  // ---- fetch stage p0 -> p1: registered read, NOP while the loader owns the array
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rd_p1       <= NOP_WORD;
      r_misalign_p1 <= 1'b0;
    end else begin
      if (r_state != S_IDLE)    r_rd_p1 <= NOP_WORD;
      else if (r_valid[w_idx])  r_rd_p1 <= r_mem[w_idx];
      else                      r_rd_p1 <= NOP_WORD;
      r_misalign_p1 <= (ra[1:0] != 2'b00);
    end
  end

  assign rd          = r_rd_p1;
  assign rd_misalign = r_misalign_p1;
  assign ld_wrap     = r_wrap;

endmodule
